// File: rtl/rggen_bus_arbiter.sv
// Round-robin arbiter that forwards one of HOSTS register-bus requests to a single downstream bus.
// Optional watchdog: define RGGEN_BUS_ARBITER_TIMEOUT_EN to abort stalled transfers after TIMEOUT_CYCLES.
module rggen_bus_arbiter #(
  parameter int unsigned HOSTS          = 2,
  parameter int unsigned ADDRESS_WIDTH  = 8,
  parameter int unsigned BUS_WIDTH      = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic [HOSTS-1:0]               i_host_valid,
  input  logic [2*HOSTS-1:0]             i_host_access,
  input  logic [ADDRESS_WIDTH*HOSTS-1:0] i_host_address,
  input  logic [BUS_WIDTH*HOSTS-1:0]     i_host_write_data,
  input  logic [BUS_WIDTH/8*HOSTS-1:0]   i_host_strobe,
  output logic [HOSTS-1:0]               o_host_ready,
  output logic [1:0]                     o_host_status,
  output logic [BUS_WIDTH-1:0]           o_host_read_data,
  output logic [HOSTS-1:0]               o_grant,
  output logic                           o_bus_valid,
  output logic [1:0]                     o_bus_access,
  output logic [ADDRESS_WIDTH-1:0]       o_bus_address,
  output logic [BUS_WIDTH-1:0]           o_bus_write_data,
  output logic [BUS_WIDTH/8-1:0]         o_bus_strobe,
  input  logic                           i_bus_ready,
  input  logic [1:0]                     i_bus_status,
  input  logic [BUS_WIDTH-1:0]           i_bus_read_data
);

  localparam int unsigned IDX_W  = (HOSTS > 1) ? $clog2(HOSTS) : 1;
  localparam int unsigned STRB_W = BUS_WIDTH / 8;

  // Elaboration-time parameter sanity check
  if (HOSTS < 1 || HOSTS > 16 || (BUS_WIDTH % 8) != 0 || TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("rggen_bus_arbiter: illegal parameter combination");
  end

  typedef enum logic {IDLE, BUSY} state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [HOSTS-1:0]   grant_q, grant_d;

  logic [IDX_W-1:0]   rr_idx;
  logic               rr_found;
  logic               granted_valid;
  logic               bus_valid_c;
  logic               done_c;
  logic               timeout_c;

  // Round robin: first valid host above last_q, else lowest valid host at or below it
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    for (int unsigned j = 0; j < HOSTS; j++) begin
      if (!rr_found && i_host_valid[j] && (IDX_W'(j) > last_q)) begin
        rr_found = 1'b1;
        rr_idx   = IDX_W'(j);
      end
    end
    for (int unsigned j = 0; j < HOSTS; j++) begin
      if (!rr_found && i_host_valid[j]) begin
        rr_found = 1'b1;
        rr_idx   = IDX_W'(j);
      end
    end
  end

  // Payload mux of the granted host; zero while idle
  always_comb begin
    granted_valid    = 1'b0;
    o_bus_access     = '0;
    o_bus_address    = '0;
    o_bus_write_data = '0;
    o_bus_strobe     = '0;
    if (state_q == BUSY) begin
      for (int unsigned j = 0; j < HOSTS; j++) begin
        if (idx_q == IDX_W'(j)) begin
          granted_valid    = i_host_valid[j];
          o_bus_access     = i_host_access[j*2+:2];
          o_bus_address    = i_host_address[j*ADDRESS_WIDTH+:ADDRESS_WIDTH];
          o_bus_write_data = i_host_write_data[j*BUS_WIDTH+:BUS_WIDTH];
          o_bus_strobe     = i_host_strobe[j*STRB_W+:STRB_W];
        end
      end
    end
  end

`ifdef RGGEN_BUS_ARBITER_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // A real bus response on the limit cycle wins over the watchdog
  assign timeout_c = (state_q == BUSY) && granted_valid && !i_bus_ready &&
                     (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == IDLE) begin
      cnt_d = '0;
    end else if (!i_bus_ready) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign timeout_c = 1'b0;
`endif

  assign bus_valid_c      = (state_q == BUSY) && granted_valid && !timeout_c;
  assign done_c           = bus_valid_c && i_bus_ready;
  assign o_bus_valid      = bus_valid_c;
  assign o_grant          = grant_q;
  assign o_host_ready     = (done_c || timeout_c) ? grant_q : '0;
  assign o_host_status    = done_c ? i_bus_status : (timeout_c ? 2'b10 : 2'b00);
  assign o_host_read_data = done_c ? i_bus_read_data : '0;

  // Next-state logic
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    last_d  = last_q;
    grant_d = grant_q;
    case (state_q)
      IDLE: begin
        if (rr_found) begin
          state_d = BUSY;
          idx_d   = rr_idx;
          grant_d = HOSTS'(1) << rr_idx;
        end
      end
      BUSY: begin
        if (done_c || timeout_c || !granted_valid) begin
          state_d = IDLE;
          last_d  = idx_q;
          grant_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      last_q  <= IDX_W'(HOSTS - 1);
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      grant_q <= grant_d;
    end
  end

endmodule

// File: tb/tb_rggen_bus_arbiter.sv
// Directed scoreboard bench for rggen_bus_arbiter (3 hosts, watchdog limit 4 when enabled).
module tb_rggen_bus_arbiter;

  localparam int unsigned HOSTS = 3;
  localparam int unsigned AW    = 8;
  localparam int unsigned BW    = 32;
  localparam int unsigned SW    = BW / 8;
  localparam int unsigned TO    = 4;
  localparam logic [1:0]  RD    = 2'b10;
  localparam logic [1:0]  WR    = 2'b11;

  logic                  clk;
  logic                  rst_n;
  logic [HOSTS-1:0]      hv;
  logic [2*HOSTS-1:0]    hacc;
  logic [AW*HOSTS-1:0]   haddr;
  logic [BW*HOSTS-1:0]   hwd;
  logic [SW*HOSTS-1:0]   hstb;
  logic [HOSTS-1:0]      o_host_ready;
  logic [1:0]            o_host_status;
  logic [BW-1:0]         o_host_read_data;
  logic [HOSTS-1:0]      o_grant;
  logic                  o_bus_valid;
  logic [1:0]            o_bus_access;
  logic [AW-1:0]         o_bus_address;
  logic [BW-1:0]         o_bus_write_data;
  logic [SW-1:0]         o_bus_strobe;
  logic                  bus_ready;
  logic [1:0]            bus_status;
  logic [BW-1:0]         bus_rdata;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int unsigned   host;
    logic [1:0]    status;
    logic [BW-1:0] data;
  } exp_t;

  exp_t sb[$];

  rggen_bus_arbiter #(
    .HOSTS          (HOSTS),
    .ADDRESS_WIDTH  (AW),
    .BUS_WIDTH      (BW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .i_clk             (clk),
    .i_rst_n           (rst_n),
    .i_host_valid      (hv),
    .i_host_access     (hacc),
    .i_host_address    (haddr),
    .i_host_write_data (hwd),
    .i_host_strobe     (hstb),
    .o_host_ready      (o_host_ready),
    .o_host_status     (o_host_status),
    .o_host_read_data  (o_host_read_data),
    .o_grant           (o_grant),
    .o_bus_valid       (o_bus_valid),
    .o_bus_access      (o_bus_access),
    .o_bus_address     (o_bus_address),
    .o_bus_write_data  (o_bus_write_data),
    .o_bus_strobe      (o_bus_strobe),
    .i_bus_ready       (bus_ready),
    .i_bus_status      (bus_status),
    .i_bus_read_data   (bus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_host(input int unsigned h, input logic v, input logic [1:0] acc,
                          input logic [AW-1:0] a, input logic [BW-1:0] d, input logic [SW-1:0] s);
    hv[h]            = v;
    hacc[h*2+:2]     = acc;
    haddr[h*AW+:AW]  = a;
    hwd[h*BW+:BW]    = d;
    hstb[h*SW+:SW]   = s;
  endtask

  task automatic expect_resp(input int unsigned h, input logic [1:0] st, input logic [BW-1:0] d);
    sb.push_back('{h, st, d});
  endtask

  task automatic next_cycle();
    @(negedge clk);
  endtask

  // Let combinational outputs settle, then retire any completion against the scoreboard
  task automatic settle();
    exp_t e;
    #1;
    if (o_host_ready !== '0) begin
      if (sb.size() == 0) begin
        check("spurious_ready", 64'(o_host_ready), 64'(0));
      end else begin
        e = sb.pop_front();
        check("resp_ready", 64'(o_host_ready), 64'(HOSTS'(1) << e.host));
        check("resp_status", 64'(o_host_status), 64'(e.status));
        check("resp_data", 64'(o_host_read_data), 64'(e.data));
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    rst_n = 1'b0; hv = '0; hacc = '0; haddr = '0; hwd = '0; hstb = '0;
    bus_ready = 1'b0; bus_status = 2'b00; bus_rdata = '0;

    // Reset: outputs held at zero even with live inputs
    next_cycle(); next_cycle();
    hv = '1; bus_ready = 1'b1; bus_status = 2'b11; bus_rdata = 32'hFFFF_FFFF;
    settle();
    check("rst_grant", 64'(o_grant), 64'(0));
    check("rst_bus_valid", 64'(o_bus_valid), 64'(0));
    check("rst_host_ready", 64'(o_host_ready), 64'(0));
    check("rst_status", 64'(o_host_status), 64'(0));
    check("rst_rdata", 64'(o_host_read_data), 64'(0));
    next_cycle();
    hv = '0; bus_ready = 1'b0; bus_status = 2'b00; bus_rdata = '0;
    rst_n = 1'b1;

    // Single write, ready two cycles after the request
    next_cycle();
    set_host(0, 1'b1, WR, 8'h10, 32'hA5A5_A5A5, 4'hF);
    settle();
    check("a_idle_valid", 64'(o_bus_valid), 64'(0));
    check("a_idle_grant", 64'(o_grant), 64'(0));
    next_cycle(); settle();
    check("a_grant", 64'(o_grant), 64'(3'b001));
    check("a_bus_valid", 64'(o_bus_valid), 64'(1));
    check("a_access", 64'(o_bus_access), 64'(WR));
    check("a_addr", 64'(o_bus_address), 64'(8'h10));
    check("a_wdata", 64'(o_bus_write_data), 64'(32'hA5A5_A5A5));
    check("a_strobe", 64'(o_bus_strobe), 64'(4'hF));
    next_cycle(); settle();
    check("a_wait_ready", 64'(o_host_ready), 64'(0));
    next_cycle();
    bus_ready = 1'b1;
    expect_resp(0, 2'b00, '0);
    settle();
    check("a_done", 64'(o_host_ready), 64'(3'b001));
    next_cycle();
    bus_ready = 1'b0;
    set_host(0, 1'b0, WR, 8'h10, 32'hA5A5_A5A5, 4'hF);
    settle();
    check("a_after_grant", 64'(o_grant), 64'(0));
    check("a_after_addr", 64'(o_bus_address), 64'(0));

    // Reset pulse, then all three hosts contend with immediate ready
    next_cycle(); rst_n = 1'b0; settle();
    next_cycle(); rst_n = 1'b1;
    for (int unsigned h = 0; h < HOSTS; h++) set_host(h, 1'b1, RD, AW'(8'h40 + h), '0, '0);
    bus_ready = 1'b1;
    for (int unsigned k = 0; k < 4; k++) begin
      settle();
      check("b_idle_grant", 64'(o_grant), 64'(0));
      check("b_idle_ready", 64'(o_host_ready), 64'(0));
      next_cycle();
      bus_rdata = BW'(32'h1000 + k);
      expect_resp(k % HOSTS, 2'b00, BW'(32'h1000 + k));
      settle();
      check("b_grant", 64'(o_grant), 64'(HOSTS'(1) << (k % HOSTS)));
      check("b_addr", 64'(o_bus_address), 64'(8'h40 + (k % HOSTS)));
      next_cycle();
    end
    hv = '0; bus_ready = 1'b0; bus_rdata = '0;
    settle();
    check("b_end_grant", 64'(o_grant), 64'(0));

    // Host 1 arrives while host 0 is busy and is served afterwards
    next_cycle();
    set_host(0, 1'b1, RD, 8'h20, '0, '0);
    settle();
    next_cycle();
    set_host(1, 1'b1, RD, 8'h30, '0, '0);
    settle();
    check("c_grant0", 64'(o_grant), 64'(3'b001));
    check("c_addr0", 64'(o_bus_address), 64'(8'h20));
    next_cycle();
    bus_ready = 1'b1; bus_rdata = 32'hCAFE_0000;
    expect_resp(0, 2'b00, 32'hCAFE_0000);
    settle();
    next_cycle();
    bus_ready = 1'b0; bus_rdata = '0;
    set_host(0, 1'b0, RD, 8'h20, '0, '0);
    settle();
    check("c_gap_grant", 64'(o_grant), 64'(0));
    next_cycle(); settle();
    check("c_grant1", 64'(o_grant), 64'(3'b010));
    check("c_addr1", 64'(o_bus_address), 64'(8'h30));
    check("c_access1", 64'(o_bus_access), 64'(RD));
    next_cycle();
    bus_ready = 1'b1; bus_rdata = 32'h1234_5678;
    expect_resp(1, 2'b00, 32'h1234_5678);
    settle();
    check("c_ready0_low", 64'(o_host_ready[0]), 64'(0));
    check("c_rdata1", 64'(o_host_read_data), 64'(32'h1234_5678));
    next_cycle();
    bus_ready = 1'b0; bus_rdata = '0;
    set_host(1, 1'b0, RD, 8'h30, '0, '0);
    settle();

    // Error status on a read
    next_cycle();
    set_host(0, 1'b1, RD, 8'h50, '0, '0);
    settle();
    next_cycle();
    bus_ready = 1'b1; bus_status = 2'b10; bus_rdata = 32'hDEAD_BEEF;
    expect_resp(0, 2'b10, 32'hDEAD_BEEF);
    settle();
    check("d_status", 64'(o_host_status), 64'(2'b10));
    check("d_ready", 64'(o_host_ready), 64'(3'b001));
    next_cycle();
    bus_ready = 1'b0; bus_status = 2'b00; bus_rdata = '0;
    set_host(0, 1'b0, RD, 8'h50, '0, '0);
    settle();

    // Granted host withdraws; pointer still advances past it
    next_cycle();
    set_host(2, 1'b1, RD, 8'h60, '0, '0);
    settle();
    next_cycle(); settle();
    check("e_grant2", 64'(o_grant), 64'(3'b100));
    next_cycle();
    set_host(2, 1'b0, RD, 8'h60, '0, '0);
    settle();
    check("e_drop_valid", 64'(o_bus_valid), 64'(0));
    check("e_drop_ready", 64'(o_host_ready), 64'(0));
    next_cycle();
    set_host(0, 1'b1, RD, 8'h70, '0, '0);
    set_host(1, 1'b1, RD, 8'h71, '0, '0);
    settle();
    check("e_idle_grant", 64'(o_grant), 64'(0));
    next_cycle(); settle();
    check("e_grant0", 64'(o_grant), 64'(3'b001));
    next_cycle();
    bus_ready = 1'b1; bus_rdata = 32'h70;
    expect_resp(0, 2'b00, 32'h70);
    settle();
    next_cycle();
    bus_ready = 1'b0; bus_rdata = '0;
    set_host(0, 1'b0, RD, 8'h70, '0, '0);
    settle();
    check("e_gap_grant", 64'(o_grant), 64'(0));
    next_cycle(); settle();
    check("e_grant1", 64'(o_grant), 64'(3'b010));
    next_cycle();
    bus_ready = 1'b1; bus_rdata = 32'h71;
    expect_resp(1, 2'b00, 32'h71);
    settle();
    next_cycle();
    bus_ready = 1'b0; bus_rdata = '0;
    set_host(1, 1'b0, RD, 8'h71, '0, '0);
    settle();

    // Stalled downstream: watchdog abort, or indefinite hold when disabled
    next_cycle();
    set_host(2, 1'b1, RD, 8'h80, '0, '0);
    settle();
`ifdef RGGEN_BUS_ARBITER_TIMEOUT_EN
    for (int unsigned c = 1; c < TO; c++) begin
      next_cycle();
      bus_rdata = 32'hFFFF_FFFF;
      settle();
      check("f_wait_valid", 64'(o_bus_valid), 64'(1));
      check("f_wait_ready", 64'(o_host_ready), 64'(0));
    end
    next_cycle();
    expect_resp(2, 2'b10, '0);
    settle();
    check("f_to_valid", 64'(o_bus_valid), 64'(0));
    check("f_to_ready", 64'(o_host_ready), 64'(3'b100));
    check("f_to_rdata", 64'(o_host_read_data), 64'(0));
    next_cycle();
    bus_rdata = '0;
    set_host(2, 1'b0, RD, 8'h80, '0, '0);
    settle();
    check("f_to_idle", 64'(o_grant), 64'(0));
`else
    for (int unsigned c = 1; c <= 8; c++) begin
      next_cycle(); settle();
      check("f_hold_grant", 64'(o_grant), 64'(3'b100));
      check("f_hold_valid", 64'(o_bus_valid), 64'(1));
      check("f_hold_ready", 64'(o_host_ready), 64'(0));
    end
    next_cycle();
    bus_ready = 1'b1; bus_rdata = 32'h80;
    expect_resp(2, 2'b00, 32'h80);
    settle();
    next_cycle();
    bus_ready = 1'b0; bus_rdata = '0;
    set_host(2, 1'b0, RD, 8'h80, '0, '0);
    settle();
    check("f_end_grant", 64'(o_grant), 64'(0));
`endif

    // Reset asserted mid-transfer aborts it
    next_cycle();
    set_host(0, 1'b1, WR, 8'h90, 32'h1, 4'h1);
    settle();
    next_cycle(); settle();
    check("g_grant", 64'(o_grant), 64'(3'b001));
    check("g_valid", 64'(o_bus_valid), 64'(1));
    #2;
    rst_n = 1'b0; bus_ready = 1'b1;
    #1;
    check("g_rst_grant", 64'(o_grant), 64'(0));
    check("g_rst_valid", 64'(o_bus_valid), 64'(0));
    check("g_rst_ready", 64'(o_host_ready), 64'(0));
    next_cycle(); next_cycle();
    rst_n = 1'b1; bus_ready = 1'b0;
    for (int unsigned h = 0; h < HOSTS; h++) set_host(h, 1'b1, RD, AW'(8'hA0 + h), '0, '0);
    settle();
    check("g_rel_grant", 64'(o_grant), 64'(0));
    next_cycle(); settle();
    check("g_first_grant", 64'(o_grant), 64'(3'b001));
    next_cycle();
    bus_ready = 1'b1; bus_rdata = 32'h99;
    expect_resp(0, 2'b00, 32'h99);
    settle();
    next_cycle();
    bus_ready = 1'b0; bus_rdata = '0; hv = '0;
    settle();

    check("sb_empty", 64'(sb.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
